// File: rtl/loader_pkg.sv
// loader_pkg: types and defaults shared by the UART instruction-memory loader.
//   state_t          loader FSM states
//   END_MARKER_ALL1  all-ones source for the default end-of-program marker
//   TIMEOUT_CYC_DEF  default inter-byte timeout, derived from clock and bit rate
//   min1_clog2()     counter width helper that never returns 0
package loader_pkg;

    typedef enum logic [1:0] {COLLECT, WRITE, CHECK, DONE} state_t;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BIT_RATE = 9600;

    // About ten bit times at 9600 baud (~52k clocks at 50 MHz): far longer than
    // any legitimate pause between bytes of one word.
    localparam int TIMEOUT_CYC_DEF = (10 * CLK_HZ) / BIT_RATE;

    // Sliced down to W bits by the top to form the default marker.
    localparam logic [63:0] END_MARKER_ALL1 = '1;

    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: instruction-memory write port driven by the loader.
//   mem_we     one-cycle write strobe
//   mem_addr   word address (ADDR_W bits)
//   mem_wdata  write data (W bits)
// Modports: master = loader side, slave = memory side.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int W      = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/loader_word_packer.sv
// loader_word_packer: assembles UART bytes into memory words.
//   clk, rst     clock, synchronous active-high reset
//   en           accept/advance enable (load enabled and loader not done)
//   rx_valid     byte strobe;  rx_data  received byte
//   rx_break     discards any partial word (wins over rx_valid)
//   word_ready   high in the cycle the final byte of a word is accepted
//   word         assembled word, complete from the cycle after word_ready
// A partial word idle for TIMEOUT_CYC clocks is dropped so the stream resyncs.
module loader_word_packer
    import loader_pkg::*;
#(
    parameter int WORD_BYTES  = 4,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    rx_break,
    output logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word
);
    localparam int CW = min1_clog2(WORD_BYTES);
    localparam int TW = min1_clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          accept;
    int            lane;

    always_comb begin
        accept     = en && rx_valid && !rx_break;
        word_ready = accept && (cnt == CW'(WORD_BYTES - 1));
        lane       = MSB_FIRST ? (WORD_BYTES - 1 - int'(cnt)) : int'(cnt);
    end

    // Stale lanes from an abandoned word are harmless: every lane is rewritten
    // before the next word_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tcnt <= '0;
            word <= '0;
        end else if (en) begin
            if (rx_break) begin
                cnt  <= '0;
                tcnt <= '0;
            end else if (rx_valid) begin
                word[8*lane +: 8] <= rx_data;
                cnt  <= word_ready ? '0 : cnt + 1'b1;
                tcnt <= '0;
            end else if (cnt != '0) begin
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    cnt  <= '0;
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: boot loader from UART bytes to instruction memory.
//   clk, rst      clock, synchronous active-high reset
//   load_en       1: bytes accepted; 0: bytes ignored, packer frozen
//   rx_valid, rx_data, rx_break   UART receiver interface
//   mbus          memory write port (uart_imem_loader_if.master)
//   write_done    sticky, program loaded (END_COUNT consecutive markers seen)
//   word_count    words written so far (saturates at DEPTH)
//   err_overflow  sticky, a word arrived with memory full
//   csum_ok       only with LOADER_CHECKSUM_EN: trailing checksum word matched
// Build option LOADER_CHECKSUM_EN: keep a sum of non-marker words written and
// take one extra word after the terminating marker as the expected sum.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int                    WORD_BYTES  = 4,
    parameter int                    ADDR_W      = 10,
    parameter bit                    MSB_FIRST   = 1'b0,
    parameter logic [8*WORD_BYTES-1:0] END_MARKER = END_MARKER_ALL1[8*WORD_BYTES-1:0],
    parameter int                    END_COUNT   = 2,
    parameter int                    TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_break,
    uart_imem_loader_if.master       mbus,
    output logic                     write_done,
    output logic [ADDR_W:0]          word_count,
    output logic                     err_overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                     csum_ok
`endif
);
    localparam int              W     = 8 * WORD_BYTES;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_nxt;
    logic [ADDR_W:0] addr;
    logic [2:0]      marker_cnt;
    logic            pk_en, word_ready, is_marker, full, last_marker;
    logic [W-1:0]    word;
`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0]    sum;
`endif

    assign pk_en = load_en && (state != DONE);

    loader_word_packer #(
        .WORD_BYTES  (WORD_BYTES),
        .MSB_FIRST   (MSB_FIRST),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .en         (pk_en),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_break   (rx_break),
        .word_ready (word_ready),
        .word       (word)
    );

    // Only meaningful in WRITE, where the packer register holds the full word.
    assign is_marker   = (word == END_MARKER);
    assign full        = (addr == DEPTH);
    assign last_marker = is_marker && (marker_cnt == 3'(END_COUNT - 1));
    assign word_count  = addr;

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        mbus.mem_we     = 1'b0;
        mbus.mem_addr   = '0;
        mbus.mem_wdata  = '0;
        write_done      = (state == DONE);
        unique case (state)
            COLLECT: if (word_ready) state_nxt = WRITE;
            WRITE: begin
                if (!full) begin
                    mbus.mem_we    = 1'b1;
                    mbus.mem_addr  = addr[ADDR_W-1:0];
                    mbus.mem_wdata = word;
                end
                // A byte accepted during WRITE may itself finish a word
                // (WORD_BYTES == 1), so word_ready is honoured here too.
                if (last_marker) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = word_ready ? DONE : CHECK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = word_ready ? WRITE : COLLECT;
                end
            end
            CHECK:   if (word_ready) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            marker_cnt   <= '0;
            err_overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            if (state == WRITE) begin
                if (full) begin
                    err_overflow <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    if (!is_marker) sum <= sum + word;
`endif
                end
                marker_cnt <= is_marker ? marker_cnt + 3'd1 : 3'd0;
            end
            // BREAK breaks any run of markers as well as the partial word.
            if (pk_en && rx_break) marker_cnt <= '0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // The packer is frozen in DONE, so it still holds the checksum word.
    assign csum_ok = (state == DONE) && (word == sum);
`endif

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: three loader instances (A: LSB first, B: MSB first,
// C: 4-word memory) driven with directed and randomized byte streams; A is
// checked against a word-level reference model of the load protocol.
module tb_uart_imem_loader;
    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [2:0] rxv, rxb, wd, ovf;
    logic [7:0] rxd [3];
    logic [10:0] wc_a, wc_b;
    logic [2:0]  wc_c;
`ifdef LOADER_CHECKSUM_EN
    logic [2:0] cs;
`endif

    always #5 clk = ~clk;

    uart_imem_loader_if #(.ADDR_W(10), .W(32)) ifa ();
    uart_imem_loader_if #(.ADDR_W(10), .W(32)) ifb ();
    uart_imem_loader_if #(.ADDR_W(2),  .W(32)) ifc ();

    uart_imem_loader #(.ADDR_W(10), .MSB_FIRST(1'b0), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rxv[0]), .rx_data(rxd[0]),
        .rx_break(rxb[0]), .mbus(ifa), .write_done(wd[0]), .word_count(wc_a),
        .err_overflow(ovf[0])
`ifdef LOADER_CHECKSUM_EN
        , .csum_ok(cs[0])
`endif
    );
    uart_imem_loader #(.ADDR_W(10), .MSB_FIRST(1'b1), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rxv[1]), .rx_data(rxd[1]),
        .rx_break(rxb[1]), .mbus(ifb), .write_done(wd[1]), .word_count(wc_b),
        .err_overflow(ovf[1])
`ifdef LOADER_CHECKSUM_EN
        , .csum_ok(cs[1])
`endif
    );
    uart_imem_loader #(.ADDR_W(2), .MSB_FIRST(1'b0), .TIMEOUT_CYC(TMO)) dut_c (
        .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rxv[2]), .rx_data(rxd[2]),
        .rx_break(rxb[2]), .mbus(ifc), .write_done(wd[2]), .word_count(wc_c),
        .err_overflow(ovf[2])
`ifdef LOADER_CHECKSUM_EN
        , .csum_ok(cs[2])
`endif
    );

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          last_stb;
    int          done_cyc_a;
    logic [63:0] got_a[$], got_b[$], got_c[$];
    int          we_cyc_a[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.mem_we) begin
            got_a.push_back({22'd0, ifa.mem_addr, ifa.mem_wdata});
            we_cyc_a.push_back(cyc);
        end
        if (ifb.mem_we) got_b.push_back({22'd0, ifb.mem_addr, ifb.mem_wdata});
        if (ifc.mem_we) got_c.push_back({30'd0, ifc.mem_addr, ifc.mem_wdata});
        if (wd[0] && done_cyc_a < 0) done_cyc_a = cyc;
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    // Word-level view of the protocol: bytes assemble LSB first; a gap of
    // TMO or more idle cycles drops a partial word; BREAK drops it and ends a
    // marker run; words go to consecutive addresses until memory is full.
    int          m_addr, m_run, m_nb;
    bit          m_done, m_ovf, m_ckwait, m_ck;
    logic [31:0] m_sum;
    logic [7:0]  m_b [4];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] wr_ent(input int a, input logic [31:0] w);
        return {32'(a), w};
    endfunction

    task automatic model_word(input logic [31:0] w);
        if (m_ckwait) begin
            m_ck   = (w == m_sum);
            m_done = 1'b1;
            return;
        end
        if (m_addr < 1024) begin
            exp_q.push_back(wr_ent(m_addr, w));
            m_addr++;
            if (w != 32'hffff_ffff) m_sum = m_sum + w;
        end else begin
            m_ovf = 1'b1;
        end
        m_run = (w == 32'hffff_ffff) ? m_run + 1 : 0;
        if (m_run == 2) begin
`ifdef LOADER_CHECKSUM_EN
            m_ckwait = 1'b1;
`else
            m_done = 1'b1;
`endif
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int gap);
        if (m_done) return;
        if (m_nb != 0 && gap >= TMO) m_nb = 0;
        m_b[m_nb] = b;
        m_nb++;
        if (m_nb == 4) begin
            m_nb = 0;
            model_word({m_b[3], m_b[2], m_b[1], m_b[0]});
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_run = 0; m_nb = 0; m_sum = '0;
        m_done = 1'b0; m_ovf = 1'b0; m_ckwait = 1'b0; m_ck = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc_set(input int d, input bit v, input bit brk, input logic [7:0] b);
        @(posedge clk);
        #1;
        rxv[d] = v;
        rxb[d] = brk;
        rxd[d] = b;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) cyc_set(d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        idle(d, gap);
        cyc_set(d, 1'b1, 1'b0, b);
        last_stb = cyc;
    endtask

    task automatic send_word(input int d, input logic [31:0] w, input int g0, input int gi,
                             input bit msb);
        for (int i = 0; i < 4; i++)
            send_byte(d, msb ? w[8*(3-i) +: 8] : w[8*i +: 8], (i == 0) ? g0 : gi);
    endtask

    task automatic a_byte(input logic [7:0] b, input int gap);
        send_byte(0, b, gap);
        model_byte(b, gap);
    endtask

    task automatic a_word(input logic [31:0] w, input int g0, input int gi);
        for (int i = 0; i < 4; i++) a_byte(w[8*i +: 8], (i == 0) ? g0 : gi);
    endtask

    task automatic a_brk();
        idle(0, 1);
        cyc_set(0, 1'b0, 1'b1, 8'h00);
        if (!m_done) begin
            m_nb  = 0;
            m_run = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; rxv = '0; rxb = '0; load_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_a.delete(); got_b.delete(); got_c.delete(); we_cyc_a.delete();
        done_cyc_a = -1;
        model_reset();
    endtask

    task automatic a_check(input string tag);
        int n;
        idle(0, 4);
        chk({tag, "_nwr"}, got_a.size(), exp_q.size());
        n = (got_a.size() < exp_q.size()) ? got_a.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr"}, got_a[i], exp_q[i]);
        chk({tag, "_done"}, wd[0], m_done);
        chk({tag, "_wc"}, wc_a, m_addr);
        chk({tag, "_ovf"}, ovf[0], m_ovf);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_csum"}, cs[0], m_done && m_ck);
`endif
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r, pg, g0;
        rst = 1'b1; load_en = 1'b1; rxv = '0; rxb = '0;
        for (int i = 0; i < 3; i++) rxd[i] = 8'h00;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_we",    ifa.mem_we, 0);
        chk("rst_addr",  ifa.mem_addr, 0);
        chk("rst_wdata", ifa.mem_wdata, 0);
        chk("rst_done",  wd, 0);
        chk("rst_wc",    wc_a, 0);
        chk("rst_ovf",   ovf, 0);

        // small program then two markers
        a_word(32'hfe01_0113, 1, 0);
        s0 = last_stb;
        a_word(32'h0011_2e23, 0, 0);
        a_word(32'h0081_2c23, 2, 1);
        a_word(32'hffff_ffff, 0, 0);
        a_word(32'hffff_ffff, 1, 0);
`ifdef LOADER_CHECKSUM_EN
        a_word(32'hfe01_0113 + 32'h0011_2e23 + 32'h0081_2c23, 0, 0);
`endif
        a_check("prog");
        chk("prog_lat", we_cyc_a.size() > 0 ? we_cyc_a[0] : -1, s0 + 1);
        chk("prog_wc", wc_a, 5);
        chk("prog_done", wd[0], 1);
`ifndef LOADER_CHECKSUM_EN
        chk("prog_done_lat", done_cyc_a, we_cyc_a.size() >= 5 ? we_cyc_a[4] + 1 : -1);
`endif

        // marker run interrupted by a normal word
        do_reset();
        a_word(32'hffff_ffff, 0, 0);
        a_word(32'h0000_0013, 0, 0);
        a_word(32'hffff_ffff, 0, 0);
        idle(0, 3);
        chk("run_early", wd[0], 0);
        a_word(32'hffff_ffff, 0, 0);
`ifdef LOADER_CHECKSUM_EN
        a_word(32'h0000_0013, 0, 0);
`endif
        a_check("run");
        chk("run_done", wd[0], 1);

        // timeout discards two stale bytes
        do_reset();
        a_byte(8'haa, 0);
        a_byte(8'hbb, 0);
        a_byte(8'h13, TMO + 1);
        a_byte(8'h00, 0); a_byte(8'h00, 0); a_byte(8'h00, 0);
        a_check("tmo");
        chk("tmo_data", got_a.size() > 0 ? got_a[0] : '1, 64'h0000_0000_0000_0013);

        // load_en low freezes the partial word and its timeout
        do_reset();
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        idle(0, 1);
        load_en = 1'b0;
        idle(0, 2 * TMO);
        send_byte(0, 8'h99, 0);
        idle(0, 1);
        load_en = 1'b1;
        send_byte(0, 8'h33, 0);
        send_byte(0, 8'h44, 0);
        idle(0, 4);
        chk("en_nwr", got_a.size(), 1);
        chk("en_data", got_a.size() > 0 ? got_a[0] : '1, 64'h0000_0000_4433_2211);

        // MSB-first lane order
        do_reset();
        send_word(1, 32'hfe01_0113, 0, 0, 1'b1);
        idle(1, 4);
        chk("msb_nwr", got_b.size(), 1);
        chk("msb_data", got_b.size() > 0 ? got_b[0] : '1, 64'h0000_0000_fe01_0113);

        // reset coinciding with the last byte: no write, partial word gone
        do_reset();
        send_byte(1, 8'h01, 0); send_byte(1, 8'h02, 0); send_byte(1, 8'h03, 0);
        @(posedge clk);
        #1;
        rxv[1] = 1'b1; rxd[1] = 8'h04; rst = 1'b1;
        @(posedge clk);
        #1;
        rxv[1] = 1'b0; rst = 1'b0;
        idle(1, 4);
        chk("rstmid_nwr", got_b.size(), 0);
        chk("rstmid_wc", wc_b, 0);
        send_word(1, 32'h0a0b_0c0d, 0, 0, 1'b1);
        idle(1, 4);
        chk("rstmid_next", got_b.size() > 0 ? got_b[0] : '1, 64'h0000_0000_0a0b_0c0d);

        // overflow on a 4-word memory
        do_reset();
        for (int i = 0; i < 5; i++) send_word(2, 32'h100 + i, 1, 0, 1'b0);
        idle(2, 4);
        chk("ovf_nwr", got_c.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("ovf_wr", i < got_c.size() ? got_c[i] : '1, wr_ent(i, 32'h100 + i));
        chk("ovf_flag", ovf[2], 1);
        chk("ovf_wc", wc_c, 4);
        chk("ovf_done", wd[2], 0);

`ifdef LOADER_CHECKSUM_EN
        // checksum match / mismatch
        do_reset();
        a_word(32'd1, 0, 0); a_word(32'd2, 0, 0);
        a_word(32'hffff_ffff, 0, 0); a_word(32'hffff_ffff, 0, 0);
        a_word(32'd3, 0, 0);
        a_check("ck_ok");
        chk("ck_ok_flag", cs[0], 1);
        do_reset();
        a_word(32'd1, 0, 0); a_word(32'd2, 0, 0);
        a_word(32'hffff_ffff, 0, 0); a_word(32'hffff_ffff, 0, 0);
        a_word(32'd4, 0, 0);
        a_check("ck_bad");
        chk("ck_bad_flag", cs[0], 0);
        chk("ck_bad_done", wd[0], 1);
`endif

        // randomized streams: words, markers, breaks, timeouts, edge gaps
        for (int round = 0; round < 3; round++) begin
            do_reset();
            pg = -1;
            for (int n = 0; n < 40; n++) begin
                r  = $urandom_range(0, 19);
                g0 = (pg >= 0) ? pg : $urandom_range(0, 3);
                pg = -1;
                if (r < 2) begin
                    a_word(32'hffff_ffff, g0, $urandom_range(0, 2));
                end else if (r < 5) begin
                    for (int k = 0; k < $urandom_range(1, 3); k++) a_byte(8'($urandom), (k == 0) ? g0 : 0);
                    if (r == 2)      a_brk();
                    else if (r == 3) pg = TMO + $urandom_range(0, 3);
                    else             pg = TMO - 1;
                end else begin
                    a_word($urandom, g0, $urandom_range(0, 2));
                end
            end
            a_word(32'hffff_ffff, (pg >= 0) ? pg : 1, 0);
            a_word(32'hffff_ffff, 0, 0);
`ifdef LOADER_CHECKSUM_EN
            a_word(m_sum, 0, 0);
`endif
            a_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
